// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART tx between NUM_REQ byte producers and holds each byte for a counted frame.
// Define UART_TX_ARB_FIXED_PRI_EN for lowest-index-wins priority instead of round-robin.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DIVISOR    = 6771,
  parameter int PKT_LEN    = 8,
  parameter int GAP_CYCLES = 6771
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [NUM_REQ-1:0]         req_valid_in,
  input  logic [NUM_REQ*8-1:0]       req_data_in,
  output logic [NUM_REQ-1:0]         req_ready_out,
  output logic                       trigger_out,
  output logic [7:0]                 val_out,
  output logic                       busy_out,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_out
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [63:0] FRAME_W = (64'(PKT_LEN) + 64'd2) * 64'(DIVISOR) + 64'(GAP_CYCLES);
  localparam logic [31:0] FRAME_CYCLES = FRAME_W[31:0];

  if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 2 || FRAME_W > 64'hFFFF_FFFF) begin : g_param_chk
    $error("uart_tx_arbiter: illegal parameters or FRAME_CYCLES exceeds 32 bits");
  end

  typedef enum logic [1:0] {IDLE, TRIG, HOLD} state_t;

  state_t        state, state_nxt;
  logic [31:0]   cnt, cnt_nxt;
  logic [IW-1:0] base, win;
  logic          found, xfer;

`ifdef UART_TX_ARB_FIXED_PRI_EN
  assign base = '0;
`else
  logic [IW-1:0] ptr;
  assign base = ptr;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in)
      ptr <= '0;
    else if (xfer)
      ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`endif

  // First asserted valid searching upward from base, wrapping at NUM_REQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++)
      if (!found && req_valid_in[IW'((int'(base) + k) % NUM_REQ)]) begin
        found = 1'b1;
        win   = IW'((int'(base) + k) % NUM_REQ);
      end
  end

  assign xfer          = (state == IDLE) && found;
  assign req_ready_out = xfer ? (NUM_REQ'(1) << win) : '0;
  assign trigger_out   = (state == TRIG);
  assign busy_out      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: state_nxt = found ? TRIG : IDLE;
      TRIG: begin
        state_nxt = HOLD;
        cnt_nxt   = FRAME_CYCLES - 1;
      end
      HOLD: begin
        state_nxt = (cnt == '0) ? IDLE : HOLD;
        cnt_nxt   = (cnt == '0) ? cnt : cnt - 1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset lands in HOLD so a frame still in flight inside tx can finish.
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state        <= HOLD;
      cnt          <= FRAME_CYCLES - 1;
      val_out      <= 8'hFF;
      grant_id_out <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (xfer) begin
        val_out      <= req_data_in[8*win +: 8];
        grant_id_out <= win;
      end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench; a cycle-index reference model predicts grants, triggers and held bytes.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int FRAME = (8 + 2) * 4 + 4;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic [N-1:0]  req_valid_in = '0;
  logic [N*8-1:0] req_data_in = '0;
  logic [N-1:0]  req_ready_out;
  logic          trigger_out;
  logic [7:0]    val_out;
  logic          busy_out;
  logic [1:0]    grant_id_out;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  int         checks = 0, failures = 0;
  int         pcyc;
  exp_t       sb[$];
  exp_t       mon_e;
  int         obs_id[$];
  logic [7:0] obs_data[$];
  int         idle_from, trig_at, ptr_m, gid_m, last_w = -1, accepts;
  logic [7:0] val_m;
`ifdef UART_TX_ARB_FIXED_PRI_EN
  int         rr_id[5] = '{0, 0, 0, 0, 0};
  logic [7:0] rr_b[5]  = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
  int         wd_id    = 0;
`else
  int         rr_id[5] = '{0, 1, 2, 3, 0};
  logic [7:0] rr_b[5]  = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
  int         wd_id    = 3;
`endif

  uart_tx_arbiter #(.NUM_REQ(N), .DIVISOR(4), .PKT_LEN(8), .GAP_CYCLES(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .req_valid_in(req_valid_in), .req_data_in(req_data_in),
    .req_ready_out(req_ready_out), .trigger_out(trigger_out), .val_out(val_out),
    .busy_out(busy_out), .grant_id_out(grant_id_out)
  );

  always #5 clk_in = ~clk_in;

  // Cycle index since reset release: 0 is the state right after release.
  always @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) pcyc <= 0;
    else pcyc <= pcyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_in)
    if (rst_n_in && trigger_out) begin
      obs_id.push_back(int'(grant_id_out));
      obs_data.push_back(val_out);
      if (sb.size() == 0) chk("unexpected_trigger", 32'd1, 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk("frame_grant", 32'(grant_id_out), 32'(mon_e.id));
        chk("frame_byte", 32'(val_out), 32'(mon_e.data));
        chk("frame_cycle", 32'(pcyc), 32'(mon_e.cyc));
      end
    end

  // Called at a negedge with inputs already driven for the coming posedge.
  task automatic tick();
    int w;
    logic [N-1:0] er;
    #1;
    w = -1;
    if (pcyc >= idle_from)
      for (int k = 0; k < N; k++) begin
        int i;
        i = (ptr_m + k) % N;
        if (w < 0 && req_valid_in[i]) w = i;
      end
    er = (w < 0) ? '0 : N'(1 << w);
    chk("ready", 32'(req_ready_out), 32'(er));
    chk("busy", 32'(busy_out), 32'(pcyc < idle_from));
    chk("trigger", 32'(trigger_out), 32'(pcyc == trig_at));
    chk("val_out", 32'(val_out), 32'(val_m));
    chk("grant_id", 32'(grant_id_out), 32'(gid_m));
    last_w = w;
    if (w >= 0) begin
      sb.push_back('{id: w, data: req_data_in[8*w +: 8], cyc: pcyc + 1});
      idle_from = pcyc + FRAME + 2;
      trig_at   = pcyc + 1;
`ifndef UART_TX_ARB_FIXED_PRI_EN
      ptr_m = (w + 1) % N;
`endif
      val_m = req_data_in[8*w +: 8];
      gid_m = w;
      accepts++;
    end
    @(negedge clk_in);
  endtask

  task automatic do_reset(int n);
    rst_n_in = 1'b0;
    repeat (n) begin
      #1;
      chk("rst_ready", 32'(req_ready_out), 32'd0);
      chk("rst_busy", 32'(busy_out), 32'd1);
      chk("rst_trigger", 32'(trigger_out), 32'd0);
      chk("rst_val", 32'(val_out), 32'hFF);
      chk("rst_grant", 32'(grant_id_out), 32'd0);
      @(negedge clk_in);
    end
    rst_n_in  = 1'b1;
    idle_from = FRAME;
    trig_at   = -1;
    ptr_m     = 0;
    gid_m     = 0;
    val_m     = 8'hFF;
    sb.delete();
  endtask

  task automatic wait_accept(int limit);
    int a0;
    a0 = accepts;
    for (int g = 0; g < limit && accepts == a0; g++) tick();
    chk("accept_timeout", 32'(accepts), 32'(a0 + 1));
  endtask

  initial begin
    @(negedge clk_in);
    req_valid_in = 4'b0001;
    req_data_in[7:0] = 8'hA5;
    do_reset(3);
    accepts = 0;
    wait_accept(FRAME + 10);
    req_valid_in = '0;
    repeat (4) tick();
    chk("reset_frame_count", 32'(obs_data.size()), 32'd1);
    if (obs_data.size() > 0) chk("reset_frame_byte", 32'(obs_data[0]), 32'hA5);

    req_data_in  = 32'h4332_2110;
    req_valid_in = 4'hF;
    do_reset(2);
    obs_id.delete();
    obs_data.delete();
    accepts = 0;
    for (int g = 0; g < 6 * (FRAME + 2) && accepts < 5; g++) tick();
    req_valid_in = '0;
    repeat (4) tick();
    chk("rr_count", 32'(obs_id.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < obs_id.size()) begin
        chk("rr_order", 32'(obs_id[i]), 32'(rr_id[i]));
        chk("rr_byte", 32'(obs_data[i]), 32'(rr_b[i]));
      end

    req_data_in[23:16] = 8'h5C;
    for (int g = 0; g < 2 * FRAME && pcyc != idle_from - 1; g++) tick();
    req_valid_in[2] = 1'b1;
    #1;
    chk("expiry_no_ready", 32'(req_ready_out), 32'd0);
    chk("expiry_val_held", 32'(val_out), 32'(val_m));
    tick();
    chk("expiry_ready_next", 32'(req_ready_out), 32'b0100);
    tick();
    req_valid_in = '0;
    repeat (3) tick();
    chk("expiry_byte", 32'(val_out), 32'h5C);

    repeat (10) tick();
    req_data_in[15:8] = 8'h77;
    req_valid_in[1]   = 1'b1;
    repeat (5) tick();
    req_valid_in = '0;
    for (int g = 0; g < 2 * FRAME && pcyc < idle_from; g++) tick();
    repeat (5) tick();
    obs_id.delete();
    req_valid_in = 4'hF;
    wait_accept(10);
    req_valid_in = '0;
    repeat (3) tick();
    chk("withdraw_frames", 32'(obs_id.size()), 32'd1);
    if (obs_id.size() > 0) chk("withdraw_ptr", 32'(obs_id[0]), 32'(wd_id));

    for (int c = 0; c < 1200; c++) begin
      for (int i = 0; i < N; i++)
        if (last_w == i) begin
          req_valid_in[i] = 1'($urandom_range(0, 1));
          req_data_in[8*i +: 8] = 8'($urandom);
        end else if (!req_valid_in[i]) begin
          if ($urandom_range(0, 7) == 0) begin
            req_valid_in[i] = 1'b1;
            req_data_in[8*i +: 8] = 8'($urandom);
          end
        end else if ($urandom_range(0, 31) == 0) req_valid_in[i] = 1'b0;
      tick();
    end

    req_valid_in = 4'b0001;
    req_data_in[7:0] = 8'h3C;
    for (int g = 0; g < 2 * FRAME && pcyc < idle_from; g++) tick();
    wait_accept(4);
    repeat (21) tick();
    do_reset(3);
    repeat (FRAME + 10) tick();
    req_valid_in = '0;
    repeat (FRAME + 6) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
